// File: rtl/spi_disp_pkg.sv
// Shared definitions for the SPI display register block: register map
// addresses, STATUS bit positions and the frame FSM state encoding.
package spi_disp_pkg;

  localparam logic [6:0] ADDR_CTRL   = 7'h10;
  localparam logic [6:0] ADDR_STATUS = 7'h11;
  localparam logic [6:0] ADDR_ID     = 7'h1F;

  localparam int STAT_ABORT    = 0;
  localparam int STAT_BAD_ADDR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte engine running in the system clock domain.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sck, mosi, cs_n   raw SPI pins (asynchronous to clk)
//   tx_load, tx_byte  parallel load of the next byte to shift out on MISO
//   cs_fall, cs_rise  one-cycle strobes on synchronised chip-select edges
//   byte_valid        one-cycle strobe on the 8th synchronised rising SCK
//   rx_byte           received byte, valid with byte_valid
//   partial           a byte is partly received (bit counter non-zero)
//   miso              serial data out, forced low while CS is high
module spi_byte_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       partial,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_sh;
  logic [7:0]             tx_sh;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  assign byte_valid = sck_rise & ~cs_s & (bit_cnt == 3'd7);
  assign rx_byte    = {rx_sh, mosi_s};
  assign partial    = (bit_cnt != 3'd0);
  assign miso       = tx_sh[7] & ~cs_s;

  // CS synchroniser resets low so that a reset in the middle of a frame
  // produces no falling edge: a new frame needs CS seen high, then low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
      bit_cnt   <= 3'd0;
      tx_sh     <= 8'h00;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      if (cs_s) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      // The falling edge after a completed byte must not shift: the MSB of
      // the freshly loaded byte has to stay on MISO for the next rise.
      if (tx_load) begin
        tx_sh <= tx_byte;
      end else if (sck_fall && !cs_s && bit_cnt != 3'd0) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sck_rise) begin
      rx_sh <= {rx_sh[5:0], mosi_s};
    end
  end

endmodule

// File: rtl/spi_disp_regs.sv
// SPI-addressed display register file with atomic commit on CS release.
// Frame: command byte {rw, addr[6:0]} followed by data bytes; the address
// auto-increments per data byte. Writes land in shadow registers and are
// copied to the display outputs one cycle after synchronised CS rises.
// Ports:
//   WF_CLK, RST_N              system clock, asynchronous active-low reset
//   SPI_CLK, SPI_MOSI, SPI_CS  SPI slave inputs (mode 0, CS active low)
//   SPI_MISO                   SPI serial data out
//   digits                     committed digit values, digit0 in the LSBs
//   colon                      00 colon, 01 decimal point, 11 none
//   blank                      display blank request
//   upd_pulse                  one-cycle strobe when committed outputs change
module spi_disp_regs
  import spi_disp_pkg::*;
#(
  parameter int         NUM_DIGITS  = 4,
  parameter int         DIGIT_W     = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic                          WF_CLK,
  input  logic                          RST_N,
  input  logic                          SPI_CLK,
  input  logic                          SPI_MOSI,
  input  logic                          SPI_CS,
  output logic                          SPI_MISO,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic [1:0]                    colon,
  output logic                          blank,
  output logic                          upd_pulse
);

  // Write data keeps only the bits any register can store.
  localparam int         WD_W         = (DIGIT_W > 3) ? DIGIT_W : 3;
  localparam logic [6:0] NUM_DIGITS_A = 7'(NUM_DIGITS);

  state_e            state_q, state_d;
  logic              cs_fall, cs_rise, byte_valid, partial;
  logic [7:0]        rx_byte;
  logic              tx_load;
  logic [7:0]        tx_byte;
  logic [6:0]        addr_q;
  logic              rw_q;
  logic              vld_p0;
  logic [6:0]        wr_addr_p0;
  logic [WD_W-1:0]   wr_data_p0;
  logic [DIGIT_W-1:0] dig_sh [NUM_DIGITS];
  logic [2:0]        ctrl_sh;
  logic [1:0]        status_q;
  logic              dirty_q;
  logic              wr_digit, wr_ctrl, wr_status, wr_bad;
  logic [1:0]        stat_set, stat_clr;
  logic              commit;

  function automatic logic [7:0] read_reg(input logic [6:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a == 7'(i)) r = 8'(dig_sh[i]);
    end
    if (a == ADDR_CTRL)   r = {5'b0, ctrl_sh};
    if (a == ADDR_STATUS) r = {6'b0, status_q};
    if (a == ADDR_ID)     r = ID_VALUE;
    return r;
  endfunction

  spi_byte_slave #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_byte (
    .clk       (WF_CLK),
    .rst_n     (RST_N),
    .sck       (SPI_CLK),
    .mosi      (SPI_MOSI),
    .cs_n      (SPI_CS),
    .tx_load   (tx_load),
    .tx_byte   (tx_byte),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .partial   (partial),
    .miso      (SPI_MISO)
  );

  always_ff @(posedge WF_CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the TX preload: ID at frame start, then either the
  // next register (read frames) or zero (write frames) at each byte end.
  always_comb begin
    state_d = state_q;
    tx_load = 1'b0;
    tx_byte = 8'h00;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = CMD;
            tx_load = 1'b1;
            tx_byte = ID_VALUE;
          end
        end
        CMD: begin
          if (byte_valid) begin
            state_d = DATA;
            tx_load = 1'b1;
            tx_byte = rx_byte[7] ? read_reg(rx_byte[6:0]) : 8'h00;
          end
        end
        DATA: begin
          if (byte_valid) begin
            tx_load = 1'b1;
            tx_byte = rw_q ? read_reg(addr_q + 7'd1) : 8'h00;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_digit  = vld_p0 && (wr_addr_p0 < NUM_DIGITS_A);
    wr_ctrl   = vld_p0 && (wr_addr_p0 == ADDR_CTRL);
    wr_status = vld_p0 && (wr_addr_p0 == ADDR_STATUS);
    wr_bad    = vld_p0 && !(wr_addr_p0 < NUM_DIGITS_A) && (wr_addr_p0 != ADDR_CTRL)
                && (wr_addr_p0 != ADDR_STATUS) && (wr_addr_p0 != ADDR_ID);
    stat_clr  = wr_status ? wr_data_p0[1:0] : 2'b00;
    stat_set  = 2'b00;
    stat_set[STAT_ABORT]    = cs_rise && (state_q != IDLE) && partial;
    stat_set[STAT_BAD_ADDR] = wr_bad;
    commit    = cs_rise && dirty_q;
  end

  // Stage p0: byte-complete strobe registered into a write request
  always_ff @(posedge WF_CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q <= 7'h00;
      rw_q   <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= byte_valid && (state_q == DATA) && !rw_q && !cs_rise;
      if (byte_valid && state_q == CMD) begin
        addr_q <= rx_byte[6:0];
        rw_q   <= rx_byte[7];
      end else if (byte_valid && state_q == DATA) begin
        addr_q <= addr_q + 7'd1;
      end
    end
  end

  always_ff @(posedge WF_CLK) begin
    if (byte_valid) begin
      wr_addr_p0 <= addr_q;
      wr_data_p0 <= rx_byte[WD_W-1:0];
    end
  end

  // Stage p1: shadow/status update, and commit to the display outputs
  always_ff @(posedge WF_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig_sh[i] <= '0;
      ctrl_sh   <= 3'b111;
      status_q  <= 2'b00;
      dirty_q   <= 1'b0;
      digits    <= '0;
      colon     <= 2'b11;
      blank     <= 1'b1;
      upd_pulse <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (vld_p0 && wr_addr_p0 == 7'(i)) dig_sh[i] <= wr_data_p0[DIGIT_W-1:0];
      end
      if (wr_ctrl) ctrl_sh <= wr_data_p0[2:0];
      // A new error event outranks a simultaneous write-1-to-clear.
      status_q <= (status_q & ~stat_clr) | stat_set;
      if (wr_digit || wr_ctrl) dirty_q <= 1'b1;
      else if (commit)         dirty_q <= 1'b0;
      upd_pulse <= commit;
      if (commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) digits[i*DIGIT_W +: DIGIT_W] <= dig_sh[i];
        colon <= ctrl_sh[1:0];
        blank <= ctrl_sh[2];
      end
    end
  end

endmodule

// File: tb/tb_spi_disp_regs.sv
module tb_spi_disp_regs;

  localparam int         NUM_DIGITS  = 4;
  localparam int         DIGIT_W     = 4;
  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] ID_VALUE    = 8'hA5;
  localparam int         HALF        = 5;
  localparam int         DW          = NUM_DIGITS * DIGIT_W;

  logic          WF_CLK   = 1'b0;
  logic          RST_N    = 1'b0;
  logic          SPI_CLK  = 1'b0;
  logic          SPI_MOSI = 1'b0;
  logic          SPI_CS   = 1'b1;
  logic          SPI_MISO;
  logic [DW-1:0] digits;
  logic [1:0]    colon;
  logic          blank;
  logic          upd_pulse;

  spi_disp_regs #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .ID_VALUE   (ID_VALUE)
  ) dut (
    .WF_CLK   (WF_CLK),
    .RST_N    (RST_N),
    .SPI_CLK  (SPI_CLK),
    .SPI_MOSI (SPI_MOSI),
    .SPI_CS   (SPI_CS),
    .SPI_MISO (SPI_MISO),
    .digits   (digits),
    .colon    (colon),
    .blank    (blank),
    .upd_pulse(upd_pulse)
  );

  always #5 WF_CLK = ~WF_CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: register map as plain integers.
  int            m_dig_sh [NUM_DIGITS];
  int            m_ctrl, m_stat;
  bit            m_dirty;
  logic [DW-1:0] m_digits;
  int            m_colon, m_blank;

  int            fr_wd [8];
  logic [7:0]    fr_rd [9];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_DIGITS; i++) m_dig_sh[i] = 0;
    m_ctrl = 7; m_stat = 0; m_dirty = 0;
    m_digits = '0; m_colon = 3; m_blank = 1;
  endtask

  function automatic int m_read(int a);
    if (a < NUM_DIGITS) return m_dig_sh[a];
    if (a == 16) return m_ctrl;
    if (a == 17) return m_stat;
    if (a == 31) return ID_VALUE;
    return 0;
  endfunction

  task automatic m_write(int a, int d);
    if (a < NUM_DIGITS) begin
      m_dig_sh[a] = d % (1 << DIGIT_W); m_dirty = 1;
    end else if (a == 16) begin
      m_ctrl = d % 8; m_dirty = 1;
    end else if (a == 17) begin
      m_stat = m_stat & ~(d % 4);
    end else if (a != 31) begin
      m_stat = m_stat | 2;
    end
  endtask

  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      SPI_MOSI = d[7-i];
      repeat (HALF) @(negedge WF_CLK);
      r[7-i] = SPI_MISO;
      SPI_CLK = 1'b1;
      repeat (HALF) @(negedge WF_CLK);
      SPI_CLK = 1'b0;
    end
  endtask

  // Raise CS just after a clock edge and watch upd_pulse for a while.
  task automatic cs_release(output int npulse, output int first);
    npulse = 0; first = -1;
    @(posedge WF_CLK);
    #1 SPI_CS = 1'b1;
    for (int i = 1; i <= SYNC_STAGES + 8; i++) begin
      @(posedge WF_CLK);
      #1;
      if (upd_pulse) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
  endtask

  // nd < 0: CS toggles with no byte at all.
  task automatic run_frame(input logic [7:0] cmd, input int nd, input int pbits, input string tag);
    int            exp_miso [9];
    int            a, npulse, first;
    logic [DW-1:0] pre_dig;
    int            pre_colon, pre_blank;
    bit            exp_pulse;
    logic [7:0]    r;
    a = int'(cmd[6:0]);
    exp_miso[0] = ID_VALUE;
    for (int k = 1; k <= nd; k++) begin
      if (cmd[7]) exp_miso[k] = m_read((a + k - 1) % 128);
      else begin
        exp_miso[k] = 0;
        m_write((a + k - 1) % 128, fr_wd[k-1]);
      end
    end
    if (pbits > 0) m_stat = m_stat | 1;
    pre_dig = m_digits; pre_colon = m_colon; pre_blank = m_blank;
    exp_pulse = m_dirty;

    @(negedge WF_CLK);
    SPI_CS = 1'b0;
    repeat (HALF) @(negedge WF_CLK);
    if (nd >= 0) begin
      spi_bits(cmd, 8, r);
      fr_rd[0] = r;
      for (int k = 1; k <= nd; k++) begin
        spi_bits(8'(fr_wd[k-1]), 8, r);
        fr_rd[k] = r;
      end
    end
    if (pbits > 0) spi_bits(8'(fr_wd[nd < 0 ? 0 : nd]), pbits, r);
    repeat (HALF) @(negedge WF_CLK);
    check_eq({tag, ".hold_digits"}, 32'(digits), 32'(pre_dig));
    check_eq({tag, ".hold_colon"}, 32'(colon), pre_colon);
    check_eq({tag, ".hold_blank"}, 32'(blank), pre_blank);

    cs_release(npulse, first);
    if (m_dirty) begin
      for (int i = 0; i < NUM_DIGITS; i++) m_digits[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(m_dig_sh[i]);
      m_colon = m_ctrl % 4;
      m_blank = (m_ctrl / 4) % 2;
      m_dirty = 0;
    end
    check_eq({tag, ".pulses"}, npulse, exp_pulse ? 1 : 0);
    if (exp_pulse) check_eq({tag, ".pulse_lat"}, first, SYNC_STAGES + 1);
    check_eq({tag, ".digits"}, 32'(digits), 32'(m_digits));
    check_eq({tag, ".colon"}, 32'(colon), m_colon);
    check_eq({tag, ".blank"}, 32'(blank), m_blank);
    for (int k = 0; k <= nd; k++) begin
      check_eq($sformatf("%s.miso%0d", tag, k), 32'(fr_rd[k]), exp_miso[k]);
    end
    repeat (2 * HALF) @(negedge WF_CLK);
  endtask

  initial begin
    int         npulse, first;
    logic [7:0] r;
    int         a;

    m_reset();
    repeat (5) @(negedge WF_CLK);
    RST_N = 1'b1;
    repeat (8) @(negedge WF_CLK);
    check_eq("rst.digits", 32'(digits), 0);
    check_eq("rst.colon", 32'(colon), 3);
    check_eq("rst.blank", 32'(blank), 1);
    check_eq("rst.upd", 32'(upd_pulse), 0);
    check_eq("rst.miso", 32'(SPI_MISO), 0);

    run_frame(8'h9F, 1, 0, "id");
    check_eq("id.byte1", 32'(fr_rd[1]), 32'hA5);

    fr_wd[0] = 1; fr_wd[1] = 2; fr_wd[2] = 3; fr_wd[3] = 4;
    run_frame(8'h00, 4, 0, "bwr");
    check_eq("bwr.value", 32'(digits), 32'h4321);

    run_frame(8'h80, 3, 0, "brd");
    check_eq("brd.b1", 32'(fr_rd[1]), 1);
    check_eq("brd.b3", 32'(fr_rd[3]), 3);

    fr_wd[0] = 0; fr_wd[1] = 8'h5A;
    run_frame(8'h10, 1, 3, "abort");
    check_eq("abort.colon00", 32'(colon), 0);
    check_eq("abort.blank0", 32'(blank), 0);
    run_frame(8'h91, 1, 0, "st_rd");
    check_eq("st_rd.abort", 32'(fr_rd[1]), 1);
    fr_wd[0] = 1;
    run_frame(8'h11, 1, 0, "st_clr");
    run_frame(8'h91, 1, 0, "st_rd2");
    check_eq("st_rd2.clear", 32'(fr_rd[1]), 0);

    fr_wd[0] = 8'h37; fr_wd[1] = 8'h09;
    run_frame(8'h7F, 2, 0, "wrap");
    check_eq("wrap.digit0", 32'(digits[3:0]), 9);
    run_frame(8'h91, 1, 0, "wrap_st");
    check_eq("wrap_st.bad", 32'(fr_rd[1]), 2);

    run_frame(8'h00, -1, 0, "noop");

    // Reset in mid-frame: the remainder of the frame must be ignored.
    @(negedge WF_CLK);
    SPI_CS = 1'b0;
    repeat (HALF) @(negedge WF_CLK);
    spi_bits(8'h00, 8, r);
    spi_bits(8'h05, 8, r);
    RST_N = 1'b0;
    repeat (3) @(negedge WF_CLK);
    check_eq("mrst.digits", 32'(digits), 0);
    check_eq("mrst.colon", 32'(colon), 3);
    check_eq("mrst.blank", 32'(blank), 1);
    RST_N = 1'b1;
    m_reset();
    spi_bits(8'h06, 8, r);
    spi_bits(8'h07, 8, r);
    repeat (HALF) @(negedge WF_CLK);
    cs_release(npulse, first);
    check_eq("mrst.pulses", npulse, 0);
    check_eq("mrst.digits2", 32'(digits), 0);
    check_eq("mrst.blank2", 32'(blank), 1);
    repeat (2 * HALF) @(negedge WF_CLK);
    run_frame(8'h80, 2, 0, "post_rst");

    for (int it = 0; it < 30; it++) begin
      int         sel, nd, pb;
      logic [7:0] cmd;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       a = $urandom_range(0, NUM_DIGITS - 1);
        1:       a = 16;
        2:       a = 17;
        3:       a = 31;
        4:       a = $urandom_range(0, 127);
        default: a = $urandom_range(126, 127);
      endcase
      cmd = {1'($urandom_range(0, 1)), 7'(a)};
      nd = $urandom_range(0, 4);
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < 8; k++) fr_wd[k] = $urandom_range(0, 255);
      run_frame(cmd, nd, pb, $sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
